// File: rtl/cpu_hazard_scoreboard_pkg.sv
// rtl/cpu_hazard_scoreboard_pkg.sv - shared constants and types for the hazard scoreboard
//
// Purpose: forwarding select codes, PC/result source codes used by the hazard
//          logic, and a bundle type for the individual stall causes.
// Ports:   none (package).

package cpu_hazard_scoreboard_pkg;

    // E-stage operand forwarding selects
    localparam logic [1:0] FORWARD_NONE      = 2'b00;
    localparam logic [1:0] FORWARD_WRITEBACK = 2'b01;
    localparam logic [1:0] FORWARD_MEMORY    = 2'b10;

    // PC source: anything other than PC+4 redirects fetch
    localparam logic [2:0] PC_SRC_PC_PLUS_4  = 3'b000;

    // Result source: data memory marks a load
    localparam logic [2:0] RESULT_SRC_DATA   = 3'b001;

    // Individual reasons the D stage must hold
    typedef struct packed {
        logic lw_stall;
        logic lu_raw;
        logic lu_full;
        logic csr_stall;
    } hazard_t;

    function automatic logic any_hazard(input hazard_t h);
        return h.lw_stall | h.lu_raw | h.lu_full | h.csr_stall;
    endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - pending-register scoreboard for long-latency units
//
// Purpose: tracks which architectural registers await a result from a
//          variable-latency unit, counts ops in flight and flags protocol
//          violations (sticky).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_issue, i_issue_rd     op dispatched, destination register
//   i_done, i_done_rd       op completed, destination register
//   i_rd_a/o_pend_a         combinational read port A
//   i_rd_b/o_pend_b         combinational read port B
//   i_waw_rd/o_pend_waw     combinational read port for WAW checks
//   o_count                 ops currently outstanding
//   o_error                 sticky protocol violation

module cpu_scoreboard #(
    parameter  int NUM_REGS        = 32,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int REG_W           = $clog2(NUM_REGS),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_issue,
    input  logic [REG_W-1:0] i_issue_rd,
    input  logic             i_done,
    input  logic [REG_W-1:0] i_done_rd,
    input  logic [REG_W-1:0] i_rd_a,
    input  logic [REG_W-1:0] i_rd_b,
    input  logic [REG_W-1:0] i_waw_rd,
    output logic             o_pend_a,
    output logic             o_pend_b,
    output logic             o_pend_waw,
    output logic [CNT_W-1:0] o_count,
    output logic             o_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]    r_count;
    logic                r_error;

    logic [NUM_REGS-1:0] w_pending_next;
    logic                w_full;
    logic                w_inc;
    logic                w_dec;
    logic                w_err_now;

    assign w_full = (r_count == CNT_MAX);
    // A completion with nothing in flight is bogus and must not wrap the count.
    assign w_dec  = i_done && (r_count != '0);
    // A completion in the same cycle frees a slot, so a full-count issue is legal then.
    assign w_inc  = i_issue && (!w_full || w_dec);

    assign w_err_now = (i_done && (r_count == '0))
                     || (i_done && (i_done_rd != '0) && !r_pending[i_done_rd])
                     || (i_issue && w_full && !w_dec);

    // Clear before set: an issue and completion to the same register keep it pending.
    always_comb begin
        w_pending_next = r_pending;
        if (i_done) begin
            w_pending_next[i_done_rd] = 1'b0;
        end
        if (i_issue) begin
            w_pending_next[i_issue_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            case ({w_inc, w_dec})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_err_now) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_pend_a   = r_pending[i_rd_a];
    assign o_pend_b   = r_pending[i_rd_b];
    assign o_pend_waw = r_pending[i_waw_rd];
    assign o_count    = r_count;
    assign o_error    = r_error;

endmodule

// File: rtl/cpu_hazard_scoreboard.sv
// rtl/cpu_hazard_scoreboard.sv - five-stage hazard unit with long-latency scoreboard
//
// Purpose: E-stage forwarding, load-use / long-latency RAW+WAW / capacity / CSR
//          drain stalls, jump and interrupt flushes, interrupt-ready handshake.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d, lu_req_d        D-stage fields, D op is long-latency
//   rs1_e, rs2_e, rd_e                  E-stage fields
//   pc_src_e, result_src_e              E-stage control (jump, load)
//   csr_write_e, lu_issue_e             E-stage CSR write, long op dispatch
//   reg_write_m, rd_m                   M-stage destination
//   reg_write_w, rd_w                   W-stage destination
//   lu_done, lu_rd                      long unit writeback
//   int_ack                             interrupt taken
//   forward_a_e, forward_b_e            forwarding selects
//   stall_f, stall_d, flush_d/e/m       pipeline control
//   int_ready                           safe point for interrupt entry
//   sb_error                            sticky scoreboard protocol violation

module cpu_hazard_scoreboard
    import cpu_hazard_scoreboard_pkg::*;
#(
    parameter  int NUM_REGS        = 32,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int CSR_DRAIN       = 2,
    localparam int REG_W           = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_d,
    input  logic             lu_req_d,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [2:0]       pc_src_e,
    input  logic [2:0]       result_src_e,
    input  logic             csr_write_e,
    input  logic             lu_issue_e,
    input  logic             reg_write_m,
    input  logic [REG_W-1:0] rd_m,
    input  logic             reg_write_w,
    input  logic [REG_W-1:0] rd_w,
    input  logic             lu_done,
    input  logic [REG_W-1:0] lu_rd,
    input  logic             int_ack,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             int_ready,
    output logic             sb_error
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int DR_W  = $clog2(CSR_DRAIN + 1);

    localparam logic [CNT_W:0]  CNT_LIMIT = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [DR_W-1:0] DR_LOAD   = DR_W'(CSR_DRAIN);

    logic [DR_W-1:0]  r_drain;

    logic             w_pend_rs1;
    logic             w_pend_rs2;
    logic             w_pend_rd;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_count_ahead;
    logic             w_jump_flush;
    logic             w_hz;
    hazard_t          w_haz;

    // M holds the younger result, so it wins over W; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             wm,
        input logic [REG_W-1:0] dm,
        input logic             ww,
        input logic [REG_W-1:0] dw
    );
        if (src == '0)             return FORWARD_NONE;
        if (wm && (dm == src))     return FORWARD_MEMORY;
        if (ww && (dw == src))     return FORWARD_WRITEBACK;
        return FORWARD_NONE;
    endfunction

    // A D-stage register conflicts if it is pending or is being claimed by E right now.
    function automatic logic lu_conflict(input logic [REG_W-1:0] r, input logic pend);
        return (r != '0) && (pend || (lu_issue_e && (r == rd_e)));
    endfunction

    cpu_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_issue    (lu_issue_e && !int_ack),
        .i_issue_rd (rd_e),
        .i_done     (lu_done),
        .i_done_rd  (lu_rd),
        .i_rd_a     (rs1_d),
        .i_rd_b     (rs2_d),
        .i_waw_rd   (rd_d),
        .o_pend_a   (w_pend_rs1),
        .o_pend_b   (w_pend_rs2),
        .o_pend_waw (w_pend_rd),
        .o_count    (w_count),
        .o_error    (sb_error)
    );

    assign forward_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    assign forward_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);

    assign w_jump_flush  = (pc_src_e != PC_SRC_PC_PLUS_4);
    // Count as it will be once the op currently in E has dispatched.
    assign w_count_ahead = {1'b0, w_count} + {{CNT_W{1'b0}}, lu_issue_e};

    assign w_haz.lw_stall  = (result_src_e == RESULT_SRC_DATA)
                           && ((rs1_d == rd_e) || (rs2_d == rd_e));
    assign w_haz.lu_raw    = lu_conflict(rs1_d, w_pend_rs1)
                           || lu_conflict(rs2_d, w_pend_rs2)
                           || lu_conflict(rd_d,  w_pend_rd);
    assign w_haz.lu_full   = lu_req_d && (w_count_ahead >= CNT_LIMIT);
    assign w_haz.csr_stall = csr_write_e || (r_drain != '0);

    assign w_hz = any_hazard(w_haz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain <= '0;
        end else if (int_ack) begin
            r_drain <= '0;
        end else if (csr_write_e) begin
            r_drain <= DR_LOAD;
        end else if (r_drain != '0) begin
            r_drain <= r_drain - 1'b1;
        end
    end

    // Interrupt entry overrides everything: squash D/E/M and let fetch redirect.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (int_ack) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            flush_d = w_jump_flush;
            flush_e = w_jump_flush | w_hz;
            stall_f = w_hz;
            stall_d = w_hz;
        end
    end

    assign int_ready = (w_count == '0) && !w_haz.csr_stall;

endmodule
